// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
// Round-robin intersection phase controller for N_DIR approaches. Each approach
// runs GREEN -> YELLOW -> ALL_RED. Green time is stretched by a per-approach
// density level. Empty approaches can be skipped. i_hold freezes the countdown.
//
// Handshake: o_tr_valid and o_phase_valid are one-clk strobes with no ready.
// A consumer samples o_tr_state / o_light / o_remain in the clk where the
// strobe is high. There is no back-pressure, so a missed strobe is simply lost.
module traffic_phase_ctrl #(
    parameter int N_DIR      = 4,
    parameter int CNT_W      = 5,
    parameter bit SKIP_EMPTY = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick_sec,
    input  logic                       i_hold,
    input  logic [CNT_W-1:0]           i_green_base,
    input  logic [CNT_W-1:0]           i_green_ext,
    input  logic [CNT_W-1:0]           i_yellow,
    input  logic [CNT_W-1:0]           i_allred,
    input  logic [2*N_DIR-1:0]         i_density,
    output logic [2*N_DIR-1:0]         o_light,
    output logic [$clog2(N_DIR)-1:0]   o_active_dir,
    output logic [CNT_W-1:0]           o_remain,
    output logic [1:0]                 o_tr_state,
    output logic                       o_tr_valid,
    output logic                       o_phase_valid,
    output logic [1:0]                 o_state
);

    localparam int DIR_W = $clog2(N_DIR);

    localparam logic [1:0] S_UPDATE = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;
    localparam logic [1:0] S_ALLRED = 2'd3;

    // Saturation ceiling for the widened green-time sum.
    localparam logic [CNT_W+1:0] G_SAT = {2'b00, {CNT_W{1'b1}}};

    logic [1:0]       state;
    logic [DIR_W-1:0] active_dir;
    logic [CNT_W-1:0] remain;
    logic [1:0]       tr_state;
    logic             tr_valid;
    logic             phase_valid;

    logic [DIR_W-1:0] cand_dir;
    logic [DIR_W-1:0] sel_dir;
    logic [1:0]       sel_dens;
    logic [CNT_W+1:0] g_full;
    logic [CNT_W-1:0] g_sat;
    logic             countdown_zero;
    logic             do_dec;

    // Next-approach selection: plain round-robin candidate, optionally
    // advanced to the first approach with non-zero density. If every approach
    // is empty the plain candidate is used.
    always_comb begin
        int   idx;
        logic found;
        cand_dir = DIR_W'((int'(active_dir) + 1) % N_DIR);
        sel_dir  = cand_dir;
        found    = 1'b0;
        idx      = 0;
        if (SKIP_EMPTY) begin
            for (int off = 1; off <= N_DIR; off++) begin
                idx = (int'(active_dir) + off) % N_DIR;
                if (!found && (i_density[2*idx +: 2] != 2'b00)) begin
                    sel_dir = DIR_W'(idx);
                    found   = 1'b1;
                end
            end
        end
        sel_dens = i_density[2*int'(sel_dir) +: 2];
    end

    // Green time = base + density*ext at CNT_W+2 bits, clamped to 2^CNT_W-1.
    always_comb begin
        g_full = {2'b00, i_green_base}
               + ((CNT_W+2)'(sel_dens) * (CNT_W+2)'(i_green_ext));
        if (g_full > G_SAT) g_sat = {CNT_W{1'b1}};
        else                g_sat = g_full[CNT_W-1:0];
    end

    // Countdown qualifiers shared by the three timed states.
    always_comb begin
        countdown_zero = (remain == '0);
        do_dec         = tick_sec && !i_hold && !countdown_zero;
    end

    // Phase sequencer: state, active approach, remaining time and strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_UPDATE;
            active_dir  <= DIR_W'(N_DIR - 1);
            remain      <= '0;
            tr_state    <= 2'b00;
            tr_valid    <= 1'b0;
            phase_valid <= 1'b0;
        end else begin
            tr_valid    <= 1'b0;
            phase_valid <= 1'b0;
            case (state)
                S_UPDATE: begin
                    active_dir  <= sel_dir;
                    tr_state    <= sel_dens;
                    remain      <= g_sat;
                    state       <= S_GREEN;
                    tr_valid    <= 1'b1;
                    phase_valid <= 1'b1;
                end
                S_GREEN: begin
                    if (countdown_zero) begin
                        state       <= S_YELLOW;
                        remain      <= i_yellow;
                        phase_valid <= 1'b1;
                    end else if (do_dec) begin
                        remain <= remain - CNT_W'(1);
                    end
                end
                S_YELLOW: begin
                    if (countdown_zero) begin
                        state       <= S_ALLRED;
                        remain      <= i_allred;
                        phase_valid <= 1'b1;
                    end else if (do_dec) begin
                        remain <= remain - CNT_W'(1);
                    end
                end
                default: begin
                    if (countdown_zero) begin
                        state <= S_UPDATE;
                    end else if (do_dec) begin
                        remain <= remain - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Light decode from registered state only; async reset clears it at once.
    always_comb begin
        o_light = '0;
        if (state == S_GREEN)       o_light[2*int'(active_dir) +: 2] = 2'b01;
        else if (state == S_YELLOW) o_light[2*int'(active_dir) +: 2] = 2'b10;
    end

    assign o_active_dir  = active_dir;
    assign o_remain      = remain;
    assign o_tr_state    = tr_state;
    assign o_tr_valid    = tr_valid;
    assign o_phase_valid = phase_valid;
    assign o_state       = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed testbench for traffic_phase_ctrl (N_DIR=4, CNT_W=5, SKIP_EMPTY=1).
// Inputs change just after the falling edge; outputs are sampled at the falling edge.
module tb_traffic_phase_ctrl;

    localparam int N_DIR = 4;
    localparam int CNT_W = 5;

    localparam logic [1:0] S_UPDATE = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;
    localparam logic [1:0] S_ALLRED = 2'd3;

    logic               clk;
    logic               reset;
    logic               tick_sec;
    logic               i_hold;
    logic [CNT_W-1:0]   i_green_base;
    logic [CNT_W-1:0]   i_green_ext;
    logic [CNT_W-1:0]   i_yellow;
    logic [CNT_W-1:0]   i_allred;
    logic [2*N_DIR-1:0] i_density;
    logic [2*N_DIR-1:0] o_light;
    logic [1:0]         o_active_dir;
    logic [CNT_W-1:0]   o_remain;
    logic [1:0]         o_tr_state;
    logic               o_tr_valid;
    logic               o_phase_valid;
    logic [1:0]         o_state;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_phase_ctrl #(.N_DIR(N_DIR), .CNT_W(CNT_W), .SKIP_EMPTY(1'b1)) dut (
        .clk(clk), .reset(reset), .tick_sec(tick_sec), .i_hold(i_hold),
        .i_green_base(i_green_base), .i_green_ext(i_green_ext),
        .i_yellow(i_yellow), .i_allred(i_allred), .i_density(i_density),
        .o_light(o_light), .o_active_dir(o_active_dir), .o_remain(o_remain),
        .o_tr_state(o_tr_state), .o_tr_valid(o_tr_valid),
        .o_phase_valid(o_phase_valid), .o_state(o_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: present tick for the next rising edge, return at falling edge.
    task automatic cyc(input logic t);
        tick_sec = t;
        @(negedge clk);
        tick_sec = 1'b0;
    endtask

    task automatic apply_reset(input logic [4:0] base, input logic [4:0] ext,
                               input logic [4:0] yel, input logic [4:0] ar,
                               input logic [7:0] dens);
        reset = 1'b0;
        i_hold = 1'b0;
        cyc(1'b0);
        i_green_base = base;
        i_green_ext  = ext;
        i_yellow     = yel;
        i_allred     = ar;
        i_density    = dens;
        cyc(1'b0);
        reset = 1'b1;
    endtask

    // Tick every clock until the next GREEN entry strobe, bounded.
    task automatic wait_green(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1);
            if (o_tr_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_hold = 1'b0;
        tick_sec = 1'b0;
        i_green_base = 5'd3; i_green_ext = 5'd2; i_yellow = 5'd2; i_allred = 5'd1;
        i_density = 8'b01_01_01_01;
        cyc(1'b1);
        cyc(1'b1);
        n_checks++; if (o_state !== S_UPDATE) begin n_fail++; $display("FAIL rst_state got %0d exp %0d", o_state, S_UPDATE); end
        n_checks++; if (o_active_dir !== 2'd3) begin n_fail++; $display("FAIL rst_dir got %0d exp 3", o_active_dir); end
        n_checks++; if (o_remain !== 5'd0) begin n_fail++; $display("FAIL rst_remain got %0d exp 0", o_remain); end
        n_checks++; if (o_tr_state !== 2'd0) begin n_fail++; $display("FAIL rst_tr_state got %0d exp 0", o_tr_state); end
        n_checks++; if (o_light !== 8'h00) begin n_fail++; $display("FAIL rst_light got %h exp 00", o_light); end
        n_checks++; if ({o_tr_valid, o_phase_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_valids got %b exp 00", {o_tr_valid, o_phase_valid}); end
    endtask

    task automatic test_basic_cycle();
        // base 3 + 1*2 = 5 ticks green, yellow 2, all-red 1.
        apply_reset(5'd3, 5'd2, 5'd2, 5'd1, 8'b01_01_01_01);
        cyc(1'b0);
        n_checks++; if (o_state !== S_GREEN) begin n_fail++; $display("FAIL g0_state got %0d exp %0d", o_state, S_GREEN); end
        n_checks++; if (o_active_dir !== 2'd0) begin n_fail++; $display("FAIL g0_dir got %0d exp 0", o_active_dir); end
        n_checks++; if (o_remain !== 5'd5) begin n_fail++; $display("FAIL g0_remain got %0d exp 5", o_remain); end
        n_checks++; if (o_tr_state !== 2'd1) begin n_fail++; $display("FAIL g0_tr_state got %0d exp 1", o_tr_state); end
        n_checks++; if ({o_tr_valid, o_phase_valid} !== 2'b11) begin n_fail++; $display("FAIL g0_strobes got %b exp 11", {o_tr_valid, o_phase_valid}); end
        n_checks++; if (o_light !== 8'h01) begin n_fail++; $display("FAIL g0_light got %h exp 01", o_light); end
        cyc(1'b0);
        n_checks++; if ({o_tr_valid, o_phase_valid} !== 2'b00) begin n_fail++; $display("FAIL g0_strobe_width got %b exp 00", {o_tr_valid, o_phase_valid}); end
        n_checks++; if (o_remain !== 5'd5) begin n_fail++; $display("FAIL g0_no_tick_hold got %0d exp 5", o_remain); end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            n_checks++; if (o_remain !== 5'(4 - i)) begin n_fail++; $display("FAIL g0_count got %0d exp %0d", o_remain, 4 - i); end
        end
        n_checks++; if (o_state !== S_GREEN) begin n_fail++; $display("FAIL g0_still_green got %0d exp %0d", o_state, S_GREEN); end
        cyc(1'b0);
        n_checks++; if (o_state !== S_YELLOW) begin n_fail++; $display("FAIL y0_state got %0d exp %0d", o_state, S_YELLOW); end
        n_checks++; if (o_remain !== 5'd2) begin n_fail++; $display("FAIL y0_remain got %0d exp 2", o_remain); end
        n_checks++; if (o_light !== 8'h02) begin n_fail++; $display("FAIL y0_light got %h exp 02", o_light); end
        n_checks++; if (o_phase_valid !== 1'b1) begin n_fail++; $display("FAIL y0_pv got %b exp 1", o_phase_valid); end
        cyc(1'b1);
        cyc(1'b1);
        n_checks++; if (o_remain !== 5'd0) begin n_fail++; $display("FAIL y0_end got %0d exp 0", o_remain); end
        // Tick coincides with remain==0: transition wins, no decrement.
        cyc(1'b1);
        n_checks++; if (o_state !== S_ALLRED) begin n_fail++; $display("FAIL ar0_state got %0d exp %0d", o_state, S_ALLRED); end
        n_checks++; if (o_remain !== 5'd1) begin n_fail++; $display("FAIL ar0_remain got %0d exp 1", o_remain); end
        n_checks++; if (o_light !== 8'h00) begin n_fail++; $display("FAIL ar0_light got %h exp 00", o_light); end
        n_checks++; if (o_phase_valid !== 1'b1) begin n_fail++; $display("FAIL ar0_pv got %b exp 1", o_phase_valid); end
        cyc(1'b1);
        cyc(1'b0);
        n_checks++; if (o_state !== S_UPDATE) begin n_fail++; $display("FAIL upd_state got %0d exp %0d", o_state, S_UPDATE); end
        n_checks++; if (o_phase_valid !== 1'b0) begin n_fail++; $display("FAIL upd_pv got %b exp 0", o_phase_valid); end
        cyc(1'b0);
        n_checks++; if (o_active_dir !== 2'd1) begin n_fail++; $display("FAIL g1_dir got %0d exp 1", o_active_dir); end
        n_checks++; if (o_light !== 8'h04) begin n_fail++; $display("FAIL g1_light got %h exp 04", o_light); end
        n_checks++; if ({o_tr_valid, o_phase_valid, o_tr_state} !== 4'b1101) begin n_fail++; $display("FAIL g1_strobes got %b exp 1101", {o_tr_valid, o_phase_valid, o_tr_state}); end
        n_checks++; if (o_remain !== 5'd5) begin n_fail++; $display("FAIL g1_remain got %0d exp 5", o_remain); end
    endtask

    task automatic test_saturation();
        // 20 + 3*7 = 41 -> clamp to 31. Next approach: 20 + 1*7 = 27.
        apply_reset(5'd20, 5'd7, 5'd0, 5'd0, 8'b01_01_01_11);
        cyc(1'b0);
        n_checks++; if (o_remain !== 5'd31) begin n_fail++; $display("FAIL sat_remain got %0d exp 31", o_remain); end
        n_checks++; if (o_tr_state !== 2'd3) begin n_fail++; $display("FAIL sat_tr_state got %0d exp 3", o_tr_state); end
        begin
            logic ok;
            wait_green(ok);
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sat_timeout got %b exp 1", ok); end
            n_checks++; if (o_remain !== 5'd27) begin n_fail++; $display("FAIL nosat_remain got %0d exp 27", o_remain); end
        end
    endtask

    task automatic test_skip();
        logic [1:0] exp_skip [4];
        logic [1:0] exp_plain[4];
        logic ok;
        exp_skip  = '{2'd0, 2'd3, 2'd0, 2'd3};
        exp_plain = '{2'd0, 2'd1, 2'd2, 2'd3};
        apply_reset(5'd1, 5'd0, 5'd0, 5'd0, 8'b10_00_00_01);
        cyc(1'b0);
        n_checks++; if (o_active_dir !== exp_skip[0]) begin n_fail++; $display("FAIL skip_0 got %0d exp %0d", o_active_dir, exp_skip[0]); end
        for (int k = 1; k < 4; k++) begin
            wait_green(ok);
            n_checks++; if (!ok || o_active_dir !== exp_skip[k]) begin n_fail++; $display("FAIL skip_%0d got %0d ok=%b exp %0d", k, o_active_dir, ok, exp_skip[k]); end
        end
        n_checks++; if (o_tr_state !== 2'd2) begin n_fail++; $display("FAIL skip_tr_state got %0d exp 2", o_tr_state); end
        i_density = 8'h00;
        for (int k = 0; k < 4; k++) begin
            wait_green(ok);
            n_checks++; if (!ok || o_active_dir !== exp_plain[k]) begin n_fail++; $display("FAIL plain_%0d got %0d ok=%b exp %0d", k, o_active_dir, ok, exp_plain[k]); end
        end
        n_checks++; if (o_tr_state !== 2'd0 || o_remain !== 5'd1) begin n_fail++; $display("FAIL plain_g got tr=%0d rem=%0d exp tr=0 rem=1", o_tr_state, o_remain); end
    endtask

    task automatic test_hold();
        int bad;
        apply_reset(5'd6, 5'd0, 5'd1, 5'd1, 8'b01_01_01_01);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        n_checks++; if (o_remain !== 5'd4) begin n_fail++; $display("FAIL hold_pre got %0d exp 4", o_remain); end
        i_hold = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1);
            if (o_remain !== 5'd4 || o_state !== S_GREEN) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_frozen got %0d bad cycles exp 0 (remain %0d)", bad, o_remain); end
        i_hold = 1'b0;
        cyc(1'b1);
        n_checks++; if (o_remain !== 5'd3) begin n_fail++; $display("FAIL hold_resume1 got %0d exp 3", o_remain); end
        cyc(1'b1);
        n_checks++; if (o_remain !== 5'd2) begin n_fail++; $display("FAIL hold_resume2 got %0d exp 2", o_remain); end
    endtask

    task automatic test_zero_durations();
        apply_reset(5'd1, 5'd0, 5'd0, 5'd0, 8'b01_01_01_01);
        cyc(1'b0);
        cyc(1'b1);
        n_checks++; if (o_remain !== 5'd0) begin n_fail++; $display("FAIL z_green_end got %0d exp 0", o_remain); end
        // Hold must not stall zero-length states.
        i_hold = 1'b1;
        cyc(1'b0);
        n_checks++; if ({o_state, o_phase_valid, o_light} !== {S_YELLOW, 1'b1, 8'h02}) begin n_fail++; $display("FAIL z_yellow got st=%0d pv=%b l=%h exp st=2 pv=1 l=02", o_state, o_phase_valid, o_light); end
        cyc(1'b0);
        n_checks++; if ({o_state, o_phase_valid, o_light} !== {S_ALLRED, 1'b1, 8'h00}) begin n_fail++; $display("FAIL z_allred got st=%0d pv=%b l=%h exp st=3 pv=1 l=00", o_state, o_phase_valid, o_light); end
        cyc(1'b0);
        n_checks++; if ({o_state, o_phase_valid} !== {S_UPDATE, 1'b0}) begin n_fail++; $display("FAIL z_update got st=%0d pv=%b exp st=0 pv=0", o_state, o_phase_valid); end
        i_hold = 1'b0;
        cyc(1'b0);
        n_checks++; if ({o_state, o_active_dir} !== {S_GREEN, 2'd1}) begin n_fail++; $display("FAIL z_next got st=%0d dir=%0d exp st=1 dir=1", o_state, o_active_dir); end
    endtask

    task automatic test_async_reset();
        apply_reset(5'd1, 5'd0, 5'd3, 5'd1, 8'b01_01_01_01);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        n_checks++; if (o_light !== 8'h02) begin n_fail++; $display("FAIL ar_pre_light got %h exp 02", o_light); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (o_light !== 8'h00) begin n_fail++; $display("FAIL ar_light got %h exp 00", o_light); end
        n_checks++; if ({o_state, o_active_dir, o_remain} !== {S_UPDATE, 2'd3, 5'd0}) begin n_fail++; $display("FAIL ar_regs got st=%0d dir=%0d rem=%0d exp st=0 dir=3 rem=0", o_state, o_active_dir, o_remain); end
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b0);
        n_checks++; if ({o_state, o_active_dir, o_light} !== {S_GREEN, 2'd0, 8'h01}) begin n_fail++; $display("FAIL ar_first_green got st=%0d dir=%0d l=%h exp st=1 dir=0 l=01", o_state, o_active_dir, o_light); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_basic_cycle();
        test_saturation();
        test_skip();
        test_hold();
        test_zero_durations();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
